// File: rtl/debug_trace_capture.sv
// Trace capture ring buffer for the SNN debug mux output: masked-compare trigger,
// programmable post-trigger length, oldest-first single-strobe readout.
module debug_trace_capture #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  debug_in,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W:0]   sample_count,
  output logic [ADDR_W-1:0] trig_index
);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t             state;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    rd_cnt;
  logic [ADDR_W-1:0]  post_cnt;
  logic [ADDR_W-1:0]  post_len_q;

  logic               capturing;
  logic               store;
  logic               match;
  logic               finish;
  logic [ADDR_W:0]    cnt_next;
  logic [ADDR_W-1:0]  wr_next;
  logic [ADDR_W-1:0]  plen_sel;

  assign capturing = (state == ARMED) || (state == POST);
  assign store     = capturing && sample_en && !arm;
  assign match     = sample_en && (((debug_in ^ trig_value) & trig_mask) == '0);
  assign cnt_next  = (sample_count == FULL) ? sample_count : sample_count + 1'b1;
  assign wr_next   = wr_ptr + 1'b1;
  assign armed     = capturing;
  assign done      = (state == DONE);

  // The DONE bookkeeping uses the post-write count/pointer, so the final store
  // and the transition happen on the same edge.
  always_comb begin
    finish   = 1'b0;
    plen_sel = post_len_q;
    if (state == ARMED) begin
      plen_sel = post_len;
      finish   = match && (post_len == '0);
    end else if (state == POST) begin
      finish   = sample_en && (post_cnt == ADDR_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && store) begin
      mem[wr_ptr] <= debug_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_cnt       <= '0;
      post_cnt     <= '0;
      post_len_q   <= '0;
      sample_count <= '0;
      triggered    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      trig_index   <= '0;
    end else if (arm) begin
      state        <= ARMED;
      wr_ptr       <= '0;
      sample_count <= '0;
      triggered    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ARMED, POST: begin
          if (sample_en) begin
            wr_ptr       <= wr_next;
            sample_count <= cnt_next;
            if (state == ARMED) begin
              if (match) begin
                triggered  <= 1'b1;
                post_len_q <= post_len;
                post_cnt   <= post_len;
                state      <= POST;
              end
            end else begin
              post_cnt <= post_cnt - 1'b1;
            end
            if (finish) begin
              state      <= DONE;
              rd_ptr     <= (cnt_next == FULL) ? wr_next : '0;
              rd_cnt     <= cnt_next;
              trig_index <= cnt_next[ADDR_W-1:0] - 1'b1 - plen_sel;
            end
          end
        end
        DONE: begin
          if (rd_en && (rd_cnt != '0)) begin
            rd_data  <= mem[rd_ptr];
            rd_valid <= 1'b1;
            rd_ptr   <= rd_ptr + 1'b1;
            rd_cnt   <= rd_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_trace_capture.sv
// Directed self-checking bench for debug_trace_capture: wrapped and early captures,
// masked triggers, sparse strobes, restart priority and reset mid-capture.
module tb_debug_trace_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       sample_en;
  logic [7:0] debug_in;
  logic [7:0] trig_mask;
  logic [7:0] trig_value;
  logic [3:0] post_len;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       armed;
  logic       triggered;
  logic       done;
  logic [4:0] sample_count;
  logic [3:0] trig_index;

  int checks = 0;
  int errors = 0;

  debug_trace_capture #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_en(sample_en), .debug_in(debug_in),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_len(post_len),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .armed(armed),
    .triggered(triggered), .done(done), .sample_count(sample_count),
    .trig_index(trig_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] din);
    sample_en = 1'b1;
    debug_in  = din;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Leaves rd_en high so consecutive calls read back-to-back.
  task automatic readWord(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic readEmpty(input string tag, input logic [7:0] held);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checkOutput({tag, "_novalid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_hold"}, 32'(rd_data), 32'(held));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_armed"}, 32'(armed), 32'd0);
    checkOutput({tag, "_trig"}, 32'(triggered), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_count"}, 32'(sample_count), 32'd0);
    checkOutput({tag, "_tidx"}, 32'(trig_index), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; sample_en = 1'b0; debug_in = 8'h00;
    trig_mask = 8'hFF; trig_value = 8'h00; post_len = 4'd0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checkIdle("reset");
    readEmpty("reset_rd", 8'h00);

    // Wrapped capture
    trig_mask = 8'hFF; trig_value = 8'h1F; post_len = 4'd4;
    pulseArm();
    checkOutput("wrap_armed", 32'(armed), 32'd1);
    checkOutput("wrap_count0", 32'(sample_count), 32'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checkOutput("wrap_rd_in_armed", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 36; i++) begin
      applyStimulus(8'(i));
      if (i == 8'h1E) checkOutput("wrap_pretrig", 32'(triggered), 32'd0);
      if (i == 8'h1F) checkOutput("wrap_trig", 32'(triggered), 32'd1);
      if (i == 8'h22) checkOutput("wrap_notdone", 32'(done), 32'd0);
      if (i == 8'h23) checkOutput("wrap_done", 32'(done), 32'd1);
    end
    checkOutput("wrap_count", 32'(sample_count), 32'd16);
    checkOutput("wrap_tidx", 32'(trig_index), 32'd11);
    checkOutput("wrap_notarmed", 32'(armed), 32'd0);
    applyStimulus(8'h99);
    checkOutput("wrap_done_ignores_sample", 32'(sample_count), 32'd16);
    for (int i = 0; i < 16; i++) readWord("wrap_rd", 8'(8'h14 + i));
    readEmpty("wrap_rd17", 8'h23);

    // Early trigger; post_len changes after the trigger must not matter
    trig_value = 8'hA2; post_len = 4'd2;
    pulseArm();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8'(8'hA0 + i));
      if (i == 2) post_len = 4'd7;
      if (i == 4) checkOutput("early_done", 32'(done), 32'd1);
    end
    checkOutput("early_count", 32'(sample_count), 32'd5);
    checkOutput("early_tidx", 32'(trig_index), 32'd2);
    for (int i = 0; i < 5; i++) readWord("early_rd", 8'(8'hA0 + i));
    readEmpty("early_rd6", 8'hA4);

    // Zero post-length with an all-zero mask
    trig_mask = 8'h00; post_len = 4'd0;
    pulseArm();
    applyStimulus(8'h5C);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_trig", 32'(triggered), 32'd1);
    checkOutput("zero_count", 32'(sample_count), 32'd1);
    checkOutput("zero_tidx", 32'(trig_index), 32'd0);
    readWord("zero_rd", 8'h5C);
    readEmpty("zero_rd2", 8'h5C);

    // Sparse strobe with partial mask
    trig_mask = 8'hE0; trig_value = 8'h80; post_len = 4'd1;
    pulseArm();
    applyStimulus(8'h10); tick(); tick();
    checkOutput("sparse_notrig", 32'(triggered), 32'd0);
    applyStimulus(8'h9F); tick(); tick();
    checkOutput("sparse_trig", 32'(triggered), 32'd1);
    checkOutput("sparse_notdone", 32'(done), 32'd0);
    applyStimulus(8'h11);
    checkOutput("sparse_done", 32'(done), 32'd1);
    checkOutput("sparse_count", 32'(sample_count), 32'd3);
    checkOutput("sparse_tidx", 32'(trig_index), 32'd1);
    readWord("sparse_rd0", 8'h10);
    readWord("sparse_rd1", 8'h9F);
    readWord("sparse_rd2", 8'h11);
    rd_en = 1'b0;

    // Restart from POST and arm-over-sample priority
    trig_mask = 8'hFF; trig_value = 8'h33; post_len = 4'd3;
    pulseArm();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h30 + i));
    checkOutput("restart_post_armed", 32'(armed), 32'd1);
    checkOutput("restart_post_trig", 32'(triggered), 32'd1);
    pulseArm();
    checkOutput("restart_count", 32'(sample_count), 32'd0);
    checkOutput("restart_armed", 32'(armed), 32'd1);
    checkOutput("restart_trig", 32'(triggered), 32'd0);
    arm = 1'b1; sample_en = 1'b1; debug_in = 8'h55;
    tick();
    arm = 1'b0; sample_en = 1'b0;
    checkOutput("prio_count", 32'(sample_count), 32'd0);

    // Reset during POST
    applyStimulus(8'h33);
    applyStimulus(8'h34);
    checkOutput("rstpost_trig", 32'(triggered), 32'd1);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checkIdle("rstpost");
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h35 + i));
    checkOutput("rstpost_idle_done", 32'(done), 32'd0);
    checkOutput("rstpost_idle_count", 32'(sample_count), 32'd0);
    readEmpty("rstpost_rd", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_trace_capture.md
Name: debug_trace_capture

Overview:
- Downstream consumer of the debug mux output: records the selected 8-bit debug word (membrane potential slice or spike vector) into a small ring buffer.
- Supports a masked-compare trigger and a programmable post-trigger length.
- After capture, the buffer is read back oldest-first through a single-strobe read port to the chip output path.
- Lets the team see SNN state around an event without sampling the pins every time-step.

Parameters:
- WIDTH, 8, debug word width.
- DEPTH, 16, buffer entries (power of two).
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  pulse; clears the buffer and starts a new capture (from any state).
- sample_en  input  1  sample strobe (SNN time-step tick); debug_in is valid when high.
- debug_in  input  WIDTH  debug word from the debug mux.
- trig_mask  input  WIDTH  bits that take part in the trigger compare.
- trig_value  input  WIDTH  compare value.
- post_len  input  ADDR_W  samples stored after the trigger sample (0..DEPTH-1).
- rd_en  input  1  readout strobe; honoured only in DONE.
- rd_data  output  WIDTH  readout word.
- rd_valid  output  1  one-cycle pulse; rd_data valid.
- armed  output  1  high in ARMED or POST.
- triggered  output  1  high from the trigger sample until the next arm or reset.
- done  output  1  high in DONE.
- sample_count  output  ADDR_W+1  stored entries, 0..DEPTH.
- trig_index  output  ADDR_W  readout position of the trigger sample; valid in DONE.

Behaviour:
- Reset (synchronous) sets these to 0, and returns the FSM to IDLE:
  - state = IDLE
  - wr_ptr, rd_ptr, read counter
  - all outputs
  - Buffer memory is not reset.
- States are IDLE, ARMED, POST, DONE.
- arm (any state):
  - Next state ARMED; wr_ptr = 0, sample_count = 0, triggered = 0, rd_valid = 0.
  - arm has priority over a same-cycle sample_en; that sample is discarded.
  - arm is ignored only when rst is high.
- Trigger match: sample_en && (((debug_in ^ trig_value) & trig_mask) == 0).
- ARMED:
  - Each sample_en writes debug_in to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - sample_count increments and saturates at DEPTH.
  - On a match, the matching sample is stored and triggered = 1.
  - If post_len == 0, go to DONE on the next edge; otherwise go to POST with post_cnt = post_len.
  - post_len is sampled at the trigger and ignored afterwards.
- POST:
  - Each sample_en stores the word as in ARMED and decrements post_cnt.
  - The write that makes post_cnt reach 0 moves the FSM to DONE.
  - Trigger compare is not evaluated in POST.
- Entry to DONE:
  - rd_ptr = (sample_count == DEPTH) ? wr_ptr : 0, i.e. the oldest entry.
  - Read counter = sample_count.
  - trig_index = sample_count - 1 - post_len, computed with the final sample_count.
- DONE readout:
  - rd_en with read counter > 0: rd_data <= mem[rd_ptr] and rd_valid = 1 the next cycle.
  - rd_ptr increments modulo DEPTH; read counter decrements.
  - rd_en with read counter == 0 is ignored (rd_valid stays 0, rd_data holds).
  - rd_en outside DONE is ignored.
  - sample_en in DONE or IDLE is ignored.
- Latency:
  - Trigger to done: post_len sample strobes, plus 1 clk.
  - rd_en to rd_valid: 1 clk.
  - Back-to-back rd_en gives one word per clk.
- Wrap-around: in ARMED, the oldest entry is overwritten once DEPTH samples are stored. The buffer holds the last DEPTH samples at DONE.
- Since post_len ≤ DEPTH-1, the trigger sample is always retained.

Test Plan:
- Reset: assert rst for 2 clk mid-activity → all outputs 0, state IDLE; rd_en pulses produce no rd_valid.
- Wrapped capture: arm; mask 0xFF, value 0x1F, post_len 4; drive debug_in = 0x00,0x01,… with sample_en every clk → triggered at 0x1F, done after 0x23 is stored, sample_count 16, trig_index 11; 16 rd_en give 0x14..0x23, a 17th gives no rd_valid.
- Early trigger: arm; value 0xA2, mask 0xFF, post_len 2; samples 0xA0..0xA6 → sample_count 5, trig_index 2, readout 0xA0,0xA1,0xA2,0xA3,0xA4.
- Zero post / masked: mask 0x00, post_len 0; first sample 0x5C → done next clk, sample_count 1, trig_index 0, readout 0x5C.
- Sparse strobe and partial mask: sample_en every 3rd clk, mask 0xE0, value 0x80; samples 0x10,0x9F,0x11 with post_len 1 → trigger on 0x9F, done after 0x11, readout 0x10,0x9F,0x11, trig_index 1.
- Restart and priority:
  - arm while in POST → sample_count 0, armed 1, triggered 0.
  - arm and sample_en in the same clk → that sample is not stored (sample_count stays 0).
  - rst during POST → IDLE, done never asserts.
